map_sst_engine: RTL

// - Save-state initiator for the mapper save-state bus: walks regs 0..N_REGS-1, captures
//   sst_di into a local buffer (SAVE) or writes buffer bytes back via sst_we_reg/sst_dato (LOAD).
// - Sits between the host/menu side (command + byte buffer port) and the sst bus of every map_xxx.
// - Mapper samples the sst bus on negedge m2, so every transfer is paced by m2 falling edges.

---
 rtl/map_sst_engine_pkg.sv | 27 ++
 rtl/map_sst_engine_sst_buf.sv | 35 +++
 rtl/map_sst_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/map_sst_engine_pkg.sv
// Shared types and constants for the mapper save-state engine.
// No logic; constants fix the register walk length, sync depth and abort window.
// No flow control lives here.
package map_sst_engine_pkg;

  localparam int SST_N_REGS  = 128;
  localparam int SST_IDX_W   = $clog2(SST_N_REGS);
  localparam int SST_ID_REG  = SST_N_REGS - 1;
  localparam int SST_M2_SYNC = 2;
  localparam int SST_TIMEOUT = 4096;
  localparam int SST_TMO_W   = $clog2(SST_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SETUP,
    ST_WAIT,
    ST_NEXT,
    ST_FIN
  } sst_state_t;

  typedef enum logic {
    MODE_SAVE,
    MODE_LOAD
  } sst_mode_t;

endpackage

// File: rtl/map_sst_engine_sst_buf.sv
// Save-state byte buffer: dual-port RAM, port A for the host, port B for the engine.
// Both ports read with 1-clk latency; writes land on the clock edge.
// No backpressure; the engine blocks host writes while busy so ports never collide.
module sst_buf
  import map_sst_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SST_IDX_W-1:0] a_addr,
  input  logic                 a_we,
  input  logic [7:0]           a_di,
  output logic [7:0]           a_do,
  input  logic [SST_IDX_W-1:0] b_addr,
  input  logic                 b_re,
  input  logic                 b_we,
  input  logic [7:0]           b_di,
  output logic [7:0]           b_do
);

  logic [7:0] mem [SST_N_REGS];

  // RAM array plus host read register; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_di;
    if (b_we) mem[b_addr] <= b_di;
    a_do <= mem[a_addr];
  end

  // Engine read register; it drives sst_dato directly, so it resets to 0 and holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    b_do <= 8'h00;
    else if (b_re) b_do <= mem[b_addr];
  end

endmodule

// File: rtl/map_sst_engine.sv
// Save-state initiator: walks mapper regs 0..N-1, capturing (SAVE) or writing back (LOAD).
// Each register holds the bus for two m2 falls (~1-2 m2 periods) plus 2 clk of overhead.
// Commands are dropped while busy; stalled m2 aborts with err after the timeout window.
module map_sst_engine
  import map_sst_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m2,
  input  logic [7:0]           map_idx,
  input  logic                 cmd_save,
  input  logic                 cmd_load,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [SST_IDX_W-1:0] buf_addr,
  input  logic                 buf_we,
  input  logic [7:0]           buf_di,
  output logic [7:0]           buf_do,
  output logic                 sst_act,
  output logic [7:0]           sst_addr,
  output logic                 sst_we_reg,
  output logic [7:0]           sst_dato,
  input  logic [7:0]           sst_di
);

  localparam logic [SST_IDX_W-1:0] ID_IDX  = SST_IDX_W'(SST_ID_REG);
  localparam logic [SST_TMO_W-1:0] TMO_MAX = SST_TMO_W'(SST_TIMEOUT - 1);

  sst_state_t             state, state_nxt;
  sst_mode_t              mode;
  logic [SST_IDX_W-1:0]   idx, addr_q, b_addr;
  logic [SST_TMO_W-1:0]   tmo_cnt;
  logic [SST_M2_SYNC-1:0] m2_sync;
  logic                   m2_prev, m2_fall, fall_cnt;
  logic                   start_save, start_load, tmo_hit, last_fall;
  logic                   b_re, b_we;
  logic [7:0]             b_do;

  assign sst_addr  = 8'(addr_q);
  assign sst_dato  = b_do;
  assign m2_fall   = m2_prev & ~m2_sync[SST_M2_SYNC-1];
  assign last_fall = m2_fall & fall_cnt;
  assign tmo_hit   = !m2_fall && (tmo_cnt == TMO_MAX);

  // Engine port: in IDLE it pre-reads the identity byte so CHECK can compare in one clock.
  assign b_addr = (state == ST_IDLE) ? ID_IDX : idx;
  assign b_re   = start_load || (state == ST_SETUP);
  assign b_we   = (state == ST_WAIT) && last_fall && (mode == MODE_SAVE);

  sst_buf u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_addr (buf_addr),
    .a_we   (buf_we && !busy),
    .a_di   (buf_di),
    .a_do   (buf_do),
    .b_addr (b_addr),
    .b_re   (b_re),
    .b_we   (b_we),
    .b_di   (sst_di),
    .b_do   (b_do)
  );

  // m2 is asynchronous to clk: synchronise, then keep one more flop for fall detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_sync <= '0;
      m2_prev <= 1'b0;
    end else begin
      m2_sync <= {m2_sync[SST_M2_SYNC-2:0], m2};
      m2_prev <= m2_sync[SST_M2_SYNC-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; SAVE has priority when both commands pulse together.
  always_comb begin
    state_nxt  = state;
    start_save = 1'b0;
    start_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_save) begin
          start_save = 1'b1;
          state_nxt  = ST_SETUP;
        end else if (cmd_load) begin
          start_load = 1'b1;
          state_nxt  = ST_CHECK;
        end
      end
      ST_CHECK: state_nxt = (b_do == map_idx) ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (last_fall)    state_nxt = ST_NEXT;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_NEXT:  state_nxt = (idx == ID_IDX) ? ST_FIN : ST_SETUP;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Walk datapath and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sst_act    <= 1'b0;
      sst_we_reg <= 1'b0;
      addr_q     <= '0;
      idx        <= '0;
      mode       <= MODE_SAVE;
      fall_cnt   <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_save || start_load) begin
            err  <= 1'b0;
            busy <= 1'b1;
            mode <= start_save ? MODE_SAVE : MODE_LOAD;
            idx  <= '0;
          end
          if (start_save) begin
            sst_act <= 1'b1;
            addr_q  <= '0;
          end
        end
        ST_CHECK: begin
          if (state_nxt == ST_IDLE) begin
            err  <= 1'b1;
            busy <= 1'b0;
          end else begin
            sst_act <= 1'b1;
            addr_q  <= idx;
          end
        end
        ST_SETUP: begin
          fall_cnt   <= 1'b0;
          tmo_cnt    <= '0;
          sst_we_reg <= (mode == MODE_LOAD) && (idx != ID_IDX);
        end
        ST_WAIT: begin
          if (m2_fall) begin
            fall_cnt <= 1'b1;
            tmo_cnt  <= '0;
            if (fall_cnt) sst_we_reg <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          if (tmo_hit) begin
            err        <= 1'b1;
            busy       <= 1'b0;
            sst_act    <= 1'b0;
            sst_we_reg <= 1'b0;
          end
        end
        ST_NEXT: begin
          if (idx == ID_IDX) begin
            sst_act    <= 1'b0;
            sst_we_reg <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            addr_q <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
